// File: rtl/click_decoder.sv
// Classifies debounced press pulses as single or double clicks using a fixed window
// after the first press, and maintains a small wrapping mode register.
module click_decoder #(
  parameter int unsigned WINDOW    = 50_000_000,
  parameter int unsigned CNT_W     = 27,
  parameter int unsigned NUM_MODES = 4,
  parameter int unsigned MODE_W    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pb_pulse,
  output logic              single_o,
  output logic              double_o,
  output logic [MODE_W-1:0] mode,
  output logic              busy
);

  typedef enum logic {StIdle, StWait} state_e;

  state_e             r_state, w_state_d;
  logic [CNT_W-1:0]   r_cnt, w_cnt_d;
  logic               r_single, w_single_d;
  logic               r_double, w_double_d;
  logic [MODE_W-1:0]  r_mode, w_mode_d;
  logic               w_timeout;
  logic [MODE_W-1:0]  w_mode_inc;

  assign w_timeout  = (r_cnt == CNT_W'(WINDOW - 1));
  assign w_mode_inc = (r_mode == MODE_W'(NUM_MODES - 1)) ? '0 : r_mode + 1'b1;

  always_comb begin
    w_state_d  = r_state;
    w_cnt_d    = r_cnt;
    w_single_d = 1'b0;
    w_double_d = 1'b0;
    w_mode_d   = r_mode;
    unique case (r_state)
      StIdle: begin
        w_cnt_d = '0;
        if (pb_pulse) begin
          w_state_d = StWait;
        end
      end
      StWait: begin
        // A second press on the timeout edge still counts as a double click.
        if (pb_pulse) begin
          w_state_d  = StIdle;
          w_cnt_d    = '0;
          w_double_d = 1'b1;
          w_mode_d   = '0;
        end else if (w_timeout) begin
          w_state_d  = StIdle;
          w_cnt_d    = '0;
          w_single_d = 1'b1;
          w_mode_d   = w_mode_inc;
        end else begin
          w_cnt_d = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_d = StIdle;
        w_cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= StIdle;
      r_cnt    <= '0;
      r_single <= 1'b0;
      r_double <= 1'b0;
      r_mode   <= '0;
    end else begin
      r_state  <= w_state_d;
      r_cnt    <= w_cnt_d;
      r_single <= w_single_d;
      r_double <= w_double_d;
      r_mode   <= w_mode_d;
    end
  end

  assign single_o = r_single;
  assign double_o = r_double;
  assign mode     = r_mode;
  assign busy     = (r_state == StWait);

endmodule

// File: tb/tb_click_decoder.sv
// Directed bench for click_decoder with WINDOW=8; each step drives one edge, then
// samples {busy, single_o, double_o, mode} 1 ns after it.
module tb_click_decoder;

  localparam int unsigned Window = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pb_pulse = 1'b0;
  logic       single_o, double_o, busy;
  logic [1:0] mode;

  int checks = 0;
  int failures = 0;

  click_decoder #(
    .WINDOW   (Window),
    .CNT_W    (4),
    .NUM_MODES(4),
    .MODE_W   (2)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .pb_pulse(pb_pulse),
    .single_o(single_o),
    .double_o(double_o),
    .mode    (mode),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  // Observation vector: {busy, single, double, mode}
  function automatic logic [4:0] obs();
    return {busy, single_o, double_o, mode};
  endfunction

  task automatic step(input logic p);
    pb_pulse = p;
    @(posedge clk);
    #1;
    pb_pulse = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(1'b0);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(i[0] == 1'b0);
      checks++;
      if (obs() !== 5'b0_0_0_00) begin
        failures++;
        $display("FAIL reset cyc%0d obs=%b exp=%b", i, obs(), 5'b0_0_0_00);
      end
    end
    rst_n = 1'b1;
  endtask

  // Full single click; verifies busy window, single pulse timing and new mode.
  task automatic run_single(input logic [1:0] exp_mode, input string nm);
    logic [1:0] prev;
    prev = mode;
    step(1'b1);
    for (int k = 1; k < int'(Window); k++) begin
      checks++;
      if (obs() !== {3'b100, prev}) begin
        failures++;
        $display("FAIL %s wait E%0d obs=%b exp=%b", nm, k - 1, obs(), {3'b100, prev});
      end
      step(1'b0);
    end
    checks++;
    if (obs() !== {3'b100, prev}) begin
      failures++;
      $display("FAIL %s wait E7 obs=%b exp=%b", nm, obs(), {3'b100, prev});
    end
    step(1'b0);
    checks++;
    if (obs() !== {3'b010, exp_mode}) begin
      failures++;
      $display("FAIL %s E8 obs=%b exp=%b", nm, obs(), {3'b010, exp_mode});
    end
  endtask

  task automatic test_single();
    logic [1:0] seq [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
    for (int r = 0; r < 4; r++) begin
      run_single(seq[r], $sformatf("single%0d", r));
    end
    step(1'b0);
    checks++;
    if (obs() !== 5'b0_0_0_00) begin
      failures++;
      $display("FAIL single_after obs=%b exp=%b", obs(), 5'b0_0_0_00);
    end
  endtask

  task automatic test_double();
    run_single(2'd1, "dbl_pre1");
    run_single(2'd2, "dbl_pre2");
    step(1'b1);
    step(1'b0);
    step(1'b0);
    step(1'b1);
    checks++;
    if (obs() !== 5'b0_0_1_00) begin
      failures++;
      $display("FAIL double_E3 obs=%b exp=%b", obs(), 5'b0_0_1_00);
    end
    step(1'b0);
    checks++;
    if (obs() !== 5'b0_0_0_00) begin
      failures++;
      $display("FAIL double_E4 obs=%b exp=%b", obs(), 5'b0_0_0_00);
    end
  endtask

  task automatic test_boundary();
    // Second press exactly on the timeout edge
    step(1'b1);
    for (int k = 1; k < int'(Window); k++) step(1'b0);
    step(1'b1);
    checks++;
    if (obs() !== 5'b0_0_1_00) begin
      failures++;
      $display("FAIL bound_E8 obs=%b exp=%b", obs(), 5'b0_0_1_00);
    end
    step(1'b0);
    checks++;
    if (obs() !== 5'b0_0_0_00) begin
      failures++;
      $display("FAIL bound_E9 obs=%b exp=%b", obs(), 5'b0_0_0_00);
    end
    // Press one edge late: single, then new WAIT from E9
    run_single(2'd1, "bound_late_a");
    step(1'b1);
    checks++;
    if (obs() !== 5'b1_0_0_01) begin
      failures++;
      $display("FAIL bound_E9new obs=%b exp=%b", obs(), 5'b1_0_0_01);
    end
    for (int k = 10; k < 17; k++) step(1'b0);
    checks++;
    if (obs() !== 5'b1_0_0_01) begin
      failures++;
      $display("FAIL bound_E16 obs=%b exp=%b", obs(), 5'b1_0_0_01);
    end
    step(1'b0);
    checks++;
    if (obs() !== 5'b0_1_0_10) begin
      failures++;
      $display("FAIL bound_E17 obs=%b exp=%b", obs(), 5'b0_1_0_10);
    end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    step(1'b1);
    for (int k = 1; k < 4; k++) step(1'b0);
    rst_n = 1'b0;
    step(1'b0);
    rst_n = 1'b1;
    checks++;
    if (obs() !== 5'b0_0_0_00) begin
      failures++;
      $display("FAIL rstwait_E4 obs=%b exp=%b", obs(), 5'b0_0_0_00);
    end
    for (int k = 0; k < 12; k++) begin
      step(1'b0);
      checks++;
      if (obs() !== 5'b0_0_0_00) begin
        failures++;
        $display("FAIL rstwait_post%0d obs=%b exp=%b", k, obs(), 5'b0_0_0_00);
      end
    end
  endtask

  task automatic test_triple();
    step(1'b1);
    step(1'b0);
    step(1'b1);
    checks++;
    if (obs() !== 5'b0_0_1_00) begin
      failures++;
      $display("FAIL triple_E2 obs=%b exp=%b", obs(), 5'b0_0_1_00);
    end
    step(1'b0);
    run_single(2'd1, "triple_tail");
  endtask

  task automatic test_back_to_back();
    // Held-high press: two consecutive high cycles make a double click
    step(1'b1);
    step(1'b1);
    checks++;
    if (obs() !== 5'b0_0_1_00) begin
      failures++;
      $display("FAIL b2b_double obs=%b exp=%b", obs(), 5'b0_0_1_00);
    end
    // Press right after a decision is a new first press
    step(1'b1);
    checks++;
    if (obs() !== 5'b1_0_0_00) begin
      failures++;
      $display("FAIL b2b_new obs=%b exp=%b", obs(), 5'b1_0_0_00);
    end
    step(1'b1);
    checks++;
    if (obs() !== 5'b0_0_1_00) begin
      failures++;
      $display("FAIL b2b_double2 obs=%b exp=%b", obs(), 5'b0_0_1_00);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_double();
    test_boundary();
    test_reset_mid_wait();
    test_triple();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
